// File: rtl/warp_pc_sched.sv
// Per-warp PC table and launch sequencer feeding the fetch stage.
// Holds one PC and one hardware warp id per slot, advances PCs on issue reports and applies branch redirects.
module warp_pc_sched #(
   parameter int unsigned PC_STRIDE = 4,
   parameter int unsigned NUM_WARPS = 32,
   parameter int unsigned ROUND_W   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [31:0]                   start_pc,
   input  logic [4:0]                    warp_id_base,
   input  logic                          stop,
   output logic [NUM_WARPS-1:0][31:0]    next_pc,
   output logic [NUM_WARPS-1:0][4:0]     warp_id,
   output logic                          initialize,
   output logic                          update_queue_valid,
   input  logic [4:0]                    warp_id_update_pc,
   input  logic                          m_tvalid_update_queue,
   input  logic                          m_tlast_update_queue,
   input  logic                          redir_valid,
   input  logic [4:0]                    redir_slot,
   input  logic [31:0]                   redir_pc,
   output logic                          busy,
   output logic [ROUND_W-1:0]            rounds_done,
   output logic [31:0]                   err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      INIT  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [NUM_WARPS-1:0][31:0]    r_next_pc;
   logic [NUM_WARPS-1:0][4:0]     r_warp_id;
   logic [ROUND_W-1:0]            r_rounds;
   logic [31:0]                   r_err;
   logic                          w_initialize;
   logic                          w_uqv;
   logic                          w_busy;
   logic                          w_active;
   logic                          w_pre_run;
   logic                          w_launch;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_state_nxt  = r_state;
      w_initialize = 1'b0;
      w_uqv        = 1'b0;
      w_busy       = 1'b1;
      w_active     = 1'b0;
      w_pre_run    = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy    = 1'b0;
            w_pre_run = 1'b1;
            if (start) w_state_nxt = LOAD;
         end
         LOAD: begin
            w_pre_run   = 1'b1;
            w_state_nxt = INIT;
         end
         INIT: begin
            w_pre_run    = 1'b1;
            w_initialize = 1'b1;
            w_uqv        = 1'b1;
            w_state_nxt  = RUN;
         end
         RUN: begin
            w_uqv    = 1'b1;
            w_active = 1'b1;
            if (stop) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            // Dropping stop here never returns to RUN; only the closing report ends the drain.
            w_uqv    = 1'b1;
            w_active = 1'b1;
            if (m_tvalid_update_queue && m_tlast_update_queue) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_launch = (r_state == IDLE) && start;

   // NOTE: sequential state uses non-blocking assignments only; later assignments to the same bit win.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the PC and warp-id tables are registers (not RAM) because fetch must see all-zero tables after reset.
         r_state   <= IDLE;
         r_next_pc <= '0;
         r_warp_id <= '0;
         r_rounds  <= '0;
         r_err     <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_launch) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
               r_next_pc[i] <= start_pc;
               r_warp_id[i] <= warp_id_base + 5'(i);
            end
            r_rounds <= '0;
            r_err    <= '0;
         end

         if (start && (r_state != IDLE)) r_err[1] <= 1'b1;
         if (m_tvalid_update_queue && w_pre_run) r_err[0] <= 1'b1;

         if (w_active) begin
            // A redirect on the slot being reported replaces the increment.
            for (int i = 0; i < NUM_WARPS; i++) begin
               if (redir_valid && (redir_slot == 5'(i))) begin
                  r_next_pc[i] <= redir_pc;
               end else if (m_tvalid_update_queue && (warp_id_update_pc == 5'(i))) begin
                  r_next_pc[i] <= r_next_pc[i] + 32'(PC_STRIDE);
               end
            end
            if (m_tvalid_update_queue && m_tlast_update_queue && (r_rounds != '1)) begin
               r_rounds <= r_rounds + ROUND_W'(1);
            end
         end
      end
   end

   assign next_pc            = r_next_pc;
   assign warp_id            = r_warp_id;
   assign initialize         = w_initialize;
   assign update_queue_valid = w_uqv;
   assign busy               = w_busy;
   assign rounds_done        = r_rounds;
   assign err                = r_err;

endmodule
